// File: rtl/dd_bus_pkg.sv
// Shared DD fill bus definitions: bus width, word type, and default
// settle time / FIFO depth used by the DD fill receiver and its FIFO.
package dd_bus_pkg;

  localparam int DD_WIDTH      = 7;
  localparam int DD_SETTLE     = 2;
  localparam int DD_FIFO_DEPTH = 4;

  typedef logic [DD_WIDTH-1:0] dd_word_t;

endpackage

// File: rtl/dd_sync_fifo.sv
// Small registered synchronous FIFO, no bypass; head is visible the cycle
// after a push. Push while full is only accepted when a pop happens too.
// Ports: clk, rst (async high), i_push/i_data, i_pop, o_data (head),
//        o_level (exact occupancy), o_full, o_empty.
module dd_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the slot the write lands in, so full+pop still accepts.
  assign w_push  = i_push & (~o_full | w_pop);

  assign o_data  = r_mem[r_rd];
  assign o_level = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + LW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - LW'(1);
    end
  end

endmodule

// File: rtl/dd_fill_receiver.sv
// DD fill bus receiver: qualifies DD_EN for SETTLE cycles, captures one
// word per enable assertion into a FIFO, and flags dropped words.
// Ports: CLK, RESET (async high), inDD/DD_EN (bus), OUT_VALID/OUT_DATA/
//        OUT_READY (consumer handshake), LEVEL, OVERFLOW (sticky), CLR_OVF.
module dd_fill_receiver
  import dd_bus_pkg::*;
#(
  parameter int WIDTH  = DD_WIDTH,
  parameter int DEPTH  = DD_FIFO_DEPTH,
  parameter int SETTLE = DD_SETTLE
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIDTH-1:0]           inDD,
  input  logic                       DD_EN,
  output logic                       OUT_VALID,
  output logic [WIDTH-1:0]           OUT_DATA,
  input  logic                       OUT_READY,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       OVERFLOW,
  input  logic                       CLR_OVF
);

  localparam int CW = $clog2(SETTLE+1);
  localparam logic [CW-1:0] CAP_AT = CW'(SETTLE-1);
  localparam logic [CW-1:0] SAT    = CW'(SETTLE);

  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          r_ovf;

  logic w_capture;
  logic w_full;
  logic w_empty;
  logic w_pop;

  assign w_capture = DD_EN & r_armed & (r_cnt == CAP_AT);
  assign w_pop     = OUT_VALID & OUT_READY;
  assign OUT_VALID = ~w_empty;
  assign OVERFLOW  = r_ovf;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (!DD_EN) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else begin
        if (r_armed && r_cnt != SAT) r_cnt <= r_cnt + CW'(1);
        if (w_capture) r_armed <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_capture && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (CLR_OVF)
        r_ovf <= 1'b0;
    end
  end

  dd_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_capture),
    .i_data  (inDD),
    .i_pop   (OUT_READY),
    .o_data  (OUT_DATA),
    .o_level (LEVEL),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_dd_fill_receiver.sv
// Self-checking bench for dd_fill_receiver: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_dd_fill_receiver;
  import dd_bus_pkg::*;

  localparam int SETTLE = DD_SETTLE;
  localparam int DEPTH  = DD_FIFO_DEPTH;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  dd_word_t   inDD = '0;
  logic       DD_EN = 1'b0;
  logic       OUT_VALID;
  dd_word_t   OUT_DATA;
  logic       OUT_READY = 1'b0;
  logic [2:0] LEVEL;
  logic       OVERFLOW;
  logic       CLR_OVF = 1'b0;

  int nchk = 0;
  int nerr = 0;

  dd_word_t q[$];
  int       run = 0;
  bit       m_ovf = 0;

  wire [11:0] w_obs = {OUT_VALID, OUT_VALID ? OUT_DATA : 7'h00,
                       LEVEL, OVERFLOW};

  dd_fill_receiver dut (
    .CLK(CLK), .RESET(RESET), .inDD(inDD), .DD_EN(DD_EN),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] mdl_vec();
    logic v;
    v = q.size() > 0;
    return {v, v ? q[0] : 7'h00, 3'(q.size()), m_ovf};
  endfunction

  task automatic mdl_reset();
    q.delete();
    run = 0;
    m_ovf = 0;
  endtask

  // Advance one clock and apply the behavioural rules to the model:
  // a word is captured on the SETTLE-th consecutive high cycle of DD_EN.
  task automatic tick();
    bit pop, push, drop;
    @(posedge CLK);
    pop  = (q.size() > 0) && OUT_READY;
    run  = DD_EN ? run + 1 : 0;
    push = DD_EN && (run == SETTLE);
    drop = 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(inDD);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (CLR_OVF) m_ovf = 0;
    #1;
  endtask

  task automatic pulse(input dd_word_t d, input int len);
    inDD = d;
    DD_EN = 1'b1;
    repeat (len) tick();
    DD_EN = 1'b0;
    tick();
  endtask

  task automatic drain_and_clear();
    OUT_READY = 1'b1;
    CLR_OVF = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    OUT_READY = 1'b0;
    CLR_OVF = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    mdl_reset();
    repeat (2) @(posedge CLK);
    #1;
    nchk++;
    if ({OUT_VALID, OUT_DATA, LEVEL, OVERFLOW} !== 12'h000) begin
      nerr++;
      $display("FAIL reset outs got %h exp 000",
               {OUT_VALID, OUT_DATA, LEVEL, OVERFLOW});
    end
    RESET = 1'b0;
    tick();
    nchk++;
    if (w_obs !== mdl_vec()) begin
      nerr++;
      $display("FAIL reset_idle got %h exp %h", w_obs, mdl_vec());
    end
  endtask

  task automatic test_basic_capture();
    inDD = 7'h55;
    DD_EN = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      nchk++;
      if (LEVEL !== ((c >= 2) ? 3'd1 : 3'd0)) begin
        nerr++;
        $display("FAIL basic_level c%0d got %0d exp %0d",
                 c, LEVEL, (c >= 2) ? 1 : 0);
      end
    end
    DD_EN = 1'b0;
    tick();
    nchk++;
    if (!OUT_VALID || OUT_DATA !== 7'h55 || w_obs !== mdl_vec()) begin
      nerr++;
      $display("FAIL basic_word got v%b d%h exp v1 d55", OUT_VALID, OUT_DATA);
    end
    drain_and_clear();
  endtask

  task automatic test_glitch();
    inDD = 7'h11;
    DD_EN = 1'b1;
    tick();
    DD_EN = 1'b0;
    tick();
    nchk++;
    if (LEVEL !== 3'd0) begin
      nerr++;
      $display("FAIL glitch_reject got level %0d exp 0", LEVEL);
    end
    pulse(7'h2A, 3);
    nchk++;
    if (LEVEL !== 3'd1 || OUT_DATA !== 7'h2A || w_obs !== mdl_vec()) begin
      nerr++;
      $display("FAIL glitch_word got l%0d d%h exp l1 d2a", LEVEL, OUT_DATA);
    end
    drain_and_clear();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) pulse(7'(i), 2);
    nchk++;
    if (LEVEL !== 3'd4 || OVERFLOW !== 1'b1) begin
      nerr++;
      $display("FAIL fill_ovf got l%0d o%b exp l4 o1", LEVEL, OVERFLOW);
    end
    OUT_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      nchk++;
      if (!OUT_VALID || OUT_DATA !== 7'(i)) begin
        nerr++;
        $display("FAIL fill_drain%0d got v%b d%h exp %h",
                 i, OUT_VALID, OUT_DATA, 7'(i));
      end
      tick();
    end
    nchk++;
    if (OUT_VALID !== 1'b0) begin
      nerr++;
      $display("FAIL fill_empty got v%b exp 0", OUT_VALID);
    end
    drain_and_clear();
  endtask

  task automatic test_push_pop_full();
    for (int i = 1; i <= 4; i++) pulse(7'(i), 2);
    inDD = 7'h7F;
    DD_EN = 1'b1;
    tick();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    DD_EN = 1'b0;
    nchk++;
    if (LEVEL !== 3'd4 || OVERFLOW !== 1'b0 || OUT_DATA !== 7'h02) begin
      nerr++;
      $display("FAIL pp_full got l%0d o%b d%h exp l4 o0 d02",
               LEVEL, OVERFLOW, OUT_DATA);
    end
    tick();
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (OUT_DATA !== ((i == 3) ? 7'h7F : 7'(i + 2))) begin
        nerr++;
        $display("FAIL pp_drain%0d got %h", i, OUT_DATA);
      end
      tick();
    end
    drain_and_clear();
  endtask

  task automatic test_clr_ovf();
    for (int i = 0; i < 5; i++) pulse(7'(8 + i), 2);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    nchk++;
    if (OVERFLOW !== 1'b0) begin
      nerr++;
      $display("FAIL clr_plain got %b exp 0", OVERFLOW);
    end
    inDD = 7'h40;
    DD_EN = 1'b1;
    tick();
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    DD_EN = 1'b0;
    nchk++;
    if (OVERFLOW !== 1'b1 || w_obs !== mdl_vec()) begin
      nerr++;
      $display("FAIL clr_vs_drop got %b exp 1", OVERFLOW);
    end
    tick();
    drain_and_clear();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) pulse(7'(20 + i), 2);
    inDD = 7'h66;
    DD_EN = 1'b1;
    tick();
    nchk++;
    if (LEVEL !== 3'd3) begin
      nerr++;
      $display("FAIL midop_pre got level %0d exp 3", LEVEL);
    end
    #3 RESET = 1'b1;
    #1;
    mdl_reset();
    nchk++;
    if ({OUT_VALID, LEVEL, OVERFLOW} !== 5'b0 || OUT_DATA !== 7'h00) begin
      nerr++;
      $display("FAIL midop_async got v%b l%0d d%h exp 0",
               OUT_VALID, LEVEL, OUT_DATA);
    end
    RESET = 1'b0;
    DD_EN = 1'b0;
    tick();
    pulse(7'h3C, 2);
    nchk++;
    if (LEVEL !== 3'd1 || OUT_DATA !== 7'h3C || w_obs !== mdl_vec()) begin
      nerr++;
      $display("FAIL midop_after got l%0d d%h exp l1 d3c", LEVEL, OUT_DATA);
    end
    drain_and_clear();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) DD_EN = ~DD_EN;
      inDD      = 7'($urandom);
      OUT_READY = ($urandom_range(0, 2) == 0);
      CLR_OVF   = ($urandom_range(0, 9) == 0);
      tick();
      nchk++;
      if (w_obs !== mdl_vec()) begin
        nerr++;
        $display("FAIL random c%0d got %h exp %h", c, w_obs, mdl_vec());
      end
    end
    DD_EN = 1'b0;
    OUT_READY = 1'b0;
    CLR_OVF = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_glitch();
    test_fill_overflow();
    test_push_pop_full();
    test_clr_ovf();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dd_fill_receiver.md
Name: dd_fill_receiver

Overview:
- Receiving end of the DRAM-side DD fill bus. The fill driver places a 7-bit value on DD while its enable is high.
- This block qualifies the enable for a settle time and captures exactly one word per enable assertion.
- Captured words go into a small FIFO and are handed to the consumer (DRAM control / refresh-address logic) over a valid/ready handshake.
- Flags overflow when words are lost.

Parameters:
WIDTH, 7, DD bus width in bits (matches DD_0..DD_6)
DEPTH, 4, FIFO entries; power of two, >=2
SETTLE, 2, consecutive cycles DD_EN must be high before capture; >=1

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
inDD  in  WIDTH  resolved DD bus value (bit i = DD_i)
DD_EN  in  1  bus-driven qualifier (the fill driver's enable)
OUT_VALID  out  1  FIFO head holds a valid word
OUT_DATA  out  WIDTH  FIFO head word; only meaningful when OUT_VALID=1
OUT_READY  in  1  consumer accepts head when OUT_VALID & OUT_READY
LEVEL  out  $clog2(DEPTH+1)  current FIFO occupancy
OVERFLOW  out  1  sticky: a capture was dropped because the FIFO was full
CLR_OVF  in  1  synchronous clear of OVERFLOW

Behaviour:
- Interface: one clock CLK; RESET is asynchronous and active-high.
- Reset: OUT_VALID=0, OUT_DATA=0, LEVEL=0, OVERFLOW=0, settle counter=0, armed=1, FIFO pointers=0. Reset asserted mid-operation discards all FIFO contents and any partial settle count immediately, not at the next edge.
- Settle counter:
  - Increments each cycle DD_EN=1 while armed, saturating at SETTLE.
  - DD_EN=0 clears the counter and sets armed=1.
- Capture:
  - Happens in the cycle where DD_EN=1, armed=1 and counter==SETTLE-1. With SETTLE=1 this is the first cycle DD_EN is seen high.
  - That cycle's inDD is sampled and pushed, and armed is cleared.
  - No further capture until DD_EN returns low; a long enable yields exactly one word.
- Glitch rejection: if DD_EN drops before the capture cycle, nothing is pushed and the counter restarts from 0 on the next assertion.
- FIFO timing:
  - Registered, no bypass. A pushed word appears on OUT_DATA with OUT_VALID=1 in the cycle after capture, even if the FIFO was empty.
  - LEVEL updates in the cycle after push/pop.
- Pop: occurs on any cycle with OUT_VALID & OUT_READY. The head advances next cycle. OUT_READY while OUT_VALID=0 has no effect.
- Full, push only: the word is dropped, LEVEL stays DEPTH, OVERFLOW is set next cycle.
- Full, push and pop in the same cycle: both are accepted, LEVEL stays DEPTH, no overflow.
- Empty, push and OUT_READY in the same cycle: push accepted, nothing popped, LEVEL becomes 1.
- Pointers: wrap modulo DEPTH. LEVEL arithmetic is exact, never wraps.
- Overflow clear: CLR_OVF=1 clears OVERFLOW next cycle. If a drop occurs in the same cycle, set wins and OVERFLOW stays 1.
- Data integrity: bit order is preserved, OUT_DATA[i] = captured DD_i. No masking by DD_EN is applied after capture.

Decomposition:
- Shared package dd_bus_pkg:
  - DD_WIDTH=7
  - typedef dd_word_t (logic [DD_WIDTH-1:0])
  - default DD_SETTLE=2 and DD_FIFO_DEPTH=4
- One sub-module, dd_sync_fifo:
  - Parameterised WIDTH/DEPTH.
  - Ports: push/pop/data, level, full/empty.
  - Same async active-high reset.
- Settle/arm logic and overflow flag stay in dd_fill_receiver.

Test Plan:
1. Basic capture. Defaults; DD_EN high 5 cycles with inDD=7'h55.
   - Exactly one word captured, on the 2nd high cycle.
   - OUT_VALID=1 with OUT_DATA=7'h55 the cycle after; LEVEL=1.
2. Glitch rejection. DD_EN high 1 cycle, low 1, high 3 with inDD=7'h2A, OUT_READY=0.
   - The first pulse is rejected; one word 7'h2A is captured; LEVEL=1.
3. Fill and overflow. Five enable pulses carrying 7'h01..7'h05, OUT_READY=0.
   - LEVEL=4, OVERFLOW=1.
   - Draining with OUT_READY=1 yields 01,02,03,04 in order, then OUT_VALID=0.
4. Full with simultaneous push and pop. FIFO full (01..04); OUT_READY=1 in the capture cycle of 7'h7F.
   - 01 popped, 7F accepted, LEVEL stays 4, OVERFLOW stays 0.
   - Drain order: 02,03,04,7F.
5. CLR_OVF. Assert CLR_OVF with no drop: OVERFLOW goes 0 next cycle. Repeat with a drop in the same cycle: OVERFLOW stays 1.
6. Reset mid-operation. LEVEL=3 and settle count=1; pulse RESET asynchronously between clock edges.
   - Outputs go to reset values immediately.
   - The next full enable pulse with 7'h3C gives LEVEL=1 and OUT_DATA=7'h3C.
